// File: rtl/led_wave_pwm.sv
// LED chaser: a PWM-dimmed head steps across the LED bank, with an optional tail over a dim background.
// Direction comes from debounced active-low buttons; travel either wraps or bounces at the ends.
module led_wave_pwm #(
   parameter int unsigned N_LED         = 10,
   parameter int unsigned PWM_BITS      = 4,
   parameter int unsigned PWM_DIV       = 31250,
   parameter int unsigned STEP_DIV_SLOW = 12500000,
   parameter int unsigned STEP_DIV_FAST = 6250000,
   parameter int unsigned DEB_CYCLES    = 500000,
   parameter int unsigned DUTY_HEAD     = 14,
   parameter int unsigned DUTY_TAIL     = 6,
   parameter int unsigned DUTY_BG       = 1,
   parameter int unsigned TAIL_LEN      = 2
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic                       Left,
   input  logic                       Right,
   input  logic                       Sw,
   input  logic                       Mode,
   output logic [N_LED-1:0]           Led,
   output logic [$clog2(N_LED)-1:0]   Pos,
   output logic [1:0]                 Dir
);

   localparam int unsigned PW       = $clog2(N_LED);
   localparam int unsigned DW       = $clog2(DEB_CYCLES + 1);
   localparam int unsigned STEP_MAX = (STEP_DIV_SLOW > STEP_DIV_FAST) ? STEP_DIV_SLOW : STEP_DIV_FAST;
   localparam int unsigned TW       = $clog2(STEP_MAX + 1);
   localparam int unsigned PDW      = $clog2(PWM_DIV + 1);
   localparam int unsigned DTW      = PWM_BITS + 1;

   localparam logic [PW-1:0]  POS_LAST  = PW'(N_LED - 1);
   localparam logic [PW-1:0]  POS_PRE   = PW'(N_LED - 2);
   localparam logic [PW-1:0]  POS_ONE   = PW'(1);
   localparam logic [DW-1:0]  DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [TW-1:0]  T_LAST_SL = TW'(STEP_DIV_SLOW - 1);
   localparam logic [TW-1:0]  T_LAST_FA = TW'(STEP_DIV_FAST - 1);
   localparam logic [PDW-1:0] PRE_LAST  = PDW'(PWM_DIV - 1);
   localparam logic [DTW-1:0] D_HEAD    = DTW'(DUTY_HEAD);
   localparam logic [DTW-1:0] D_TAIL    = DTW'(DUTY_TAIL);
   localparam logic [DTW-1:0] D_BG      = DTW'(DUTY_BG);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_UP   = 2'b10,
      ST_DOWN = 2'b01
   } state_t;

   // Button index 0 = Left, 1 = Right
   logic [1:0]          btn_s1_q, btn_s1_d;
   logic [1:0]          btn_s2_q, btn_s2_d;
   logic [1:0]          btn_acc_q, btn_acc_d;
   logic [1:0]          press_q, press_d;
   logic [1:0][DW-1:0]  deb_cnt_q, deb_cnt_d;

   logic                sw_q, sw_d;
   logic [TW-1:0]       step_cnt_q, step_cnt_d;
   logic                sw_chg, tick;
   logic [TW-1:0]       t_last;

   state_t              state_q, state_d;
   logic [PW-1:0]       pos_q, pos_d;

   logic [PDW-1:0]      pre_q, pre_d;
   logic [PWM_BITS-1:0] slot_q, slot_d;
   logic                pre_wrap;

   logic [N_LED-1:0]    led_q, led_d;
   logic [DTW-1:0]      duty;
   int unsigned         p, d;

   always_comb begin
      btn_s1_d  = {Right, Left};
      btn_s2_d  = btn_s1_q;
      btn_acc_d = btn_acc_q;
      deb_cnt_d = deb_cnt_q;
      press_d   = '0;
      for (int unsigned b = 0; b < 2; b++) begin
         if (btn_s2_q[b] == btn_acc_q[b]) begin
            deb_cnt_d[b] = '0;
         end else if (deb_cnt_q[b] == DEB_LAST) begin
            btn_acc_d[b] = btn_s2_q[b];
            deb_cnt_d[b] = '0;
            press_d[b]   = ~btn_s2_q[b];
         end else begin
            deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
         end
      end
   end

   // A sampled speed change restarts the period without producing a tick
   always_comb begin
      sw_d       = Sw;
      sw_chg     = (Sw != sw_q);
      t_last     = sw_q ? T_LAST_FA : T_LAST_SL;
      tick       = !sw_chg && (step_cnt_q == t_last);
      step_cnt_d = (sw_chg || tick) ? '0 : step_cnt_q + 1'b1;
   end

   // Movement uses the pre-press state; a same-cycle press then overrides the next state
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      if (tick) begin
         case (state_q)
            ST_UP: begin
               if (pos_q == POS_LAST) begin
                  if (Mode) begin
                     state_d = ST_DOWN;
                     pos_d   = POS_PRE;
                  end else begin
                     pos_d = '0;
                  end
               end else begin
                  pos_d = pos_q + 1'b1;
               end
            end
            ST_DOWN: begin
               if (pos_q == '0) begin
                  if (Mode) begin
                     state_d = ST_UP;
                     pos_d   = POS_ONE;
                  end else begin
                     pos_d = POS_LAST;
                  end
               end else begin
                  pos_d = pos_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
      if (press_q[0] && !press_q[1] && state_q != ST_UP) begin
         state_d = ST_UP;
      end else if (press_q[1] && !press_q[0] && state_q != ST_DOWN) begin
         state_d = ST_DOWN;
      end
   end

   always_comb begin
      pre_wrap = (pre_q == PRE_LAST);
      pre_d    = pre_wrap ? '0 : pre_q + 1'b1;
      slot_d   = pre_wrap ? slot_q + 1'b1 : slot_q;
   end

   // d is the distance behind the head along the travel direction
   always_comb begin
      led_d = '0;
      duty  = D_BG;
      p     = 32'(pos_q);
      d     = 0;
      for (int unsigned i = 0; i < N_LED; i++) begin
         duty = D_BG;
         d    = 0;
         if (i == p) begin
            duty = D_HEAD;
         end else if (state_q == ST_UP) begin
            d = (p >= i) ? (p - i) : (p + N_LED - i);
            if (d <= TAIL_LEN && (!Mode || p > i)) duty = D_TAIL;
         end else if (state_q == ST_DOWN) begin
            d = (i >= p) ? (i - p) : (i + N_LED - p);
            if (d <= TAIL_LEN && (!Mode || i > p)) duty = D_TAIL;
         end
         led_d[i] = ({1'b0, slot_q} < duty);
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         btn_s1_q   <= '1;
         btn_s2_q   <= '1;
         btn_acc_q  <= '1;
         press_q    <= '0;
         deb_cnt_q  <= '0;
         sw_q       <= 1'b0;
         step_cnt_q <= '0;
         state_q    <= ST_IDLE;
         pos_q      <= '0;
         pre_q      <= '0;
         slot_q     <= '0;
         led_q      <= '0;
      end else begin
         btn_s1_q   <= btn_s1_d;
         btn_s2_q   <= btn_s2_d;
         btn_acc_q  <= btn_acc_d;
         press_q    <= press_d;
         deb_cnt_q  <= deb_cnt_d;
         sw_q       <= sw_d;
         step_cnt_q <= step_cnt_d;
         state_q    <= state_d;
         pos_q      <= pos_d;
         pre_q      <= pre_d;
         slot_q     <= slot_d;
         led_q      <= led_d;
      end
   end

   assign Led = led_q;
   assign Pos = pos_q;
   assign Dir = state_q;

endmodule

// File: tb/tb_led_wave_pwm.sv
// Directed bench for led_wave_pwm with small timing parameters and hand-computed expectations.
module tb_led_wave_pwm;

   logic       Clk = 1'b0;
   logic       Rst, Left, Right, Sw, Mode;
   logic [4:0] Led;
   logic [2:0] Pos;
   logic [1:0] Dir;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned n;
   int unsigned on_cnt [5];

   int unsigned wrap_seq   [5] = '{2, 3, 4, 0, 1};
   int unsigned bnc_pos    [8] = '{2, 3, 4, 3, 2, 1, 0, 1};
   int unsigned bnc_dir    [8] = '{2, 2, 2, 1, 1, 1, 1, 2};
   int unsigned frame_p2   [5] = '{0, 2, 3, 0, 0};
   int unsigned frame_p0w  [5] = '{3, 0, 0, 0, 2};
   int unsigned frame_p0b  [5] = '{3, 0, 0, 0, 0};

   led_wave_pwm #(
      .N_LED(5), .PWM_BITS(2), .PWM_DIV(1),
      .STEP_DIV_SLOW(20), .STEP_DIV_FAST(10), .DEB_CYCLES(4),
      .DUTY_HEAD(3), .DUTY_TAIL(2), .DUTY_BG(0), .TAIL_LEN(1)
   ) dut (
      .Clk(Clk), .Rst(Rst), .Left(Left), .Right(Right),
      .Sw(Sw), .Mode(Mode), .Led(Led), .Pos(Pos), .Dir(Dir)
   );

   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int unsigned k);
      repeat (k) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic wait_pos(input int unsigned limit, output int unsigned cyc);
      logic [2:0] old;
      old = Pos;
      cyc = 0;
      while (Pos == old && cyc < limit) begin
         step(1);
         cyc++;
      end
   endtask

   // One settling edge for the registered LED output, then one full 4-slot frame
   task automatic measure();
      for (int unsigned i = 0; i < 5; i++) on_cnt[i] = 0;
      step(1);
      repeat (4) begin
         step(1);
         for (int unsigned i = 0; i < 5; i++) if (Led[i]) on_cnt[i]++;
      end
   endtask

   task automatic check_frame(input string tag, input int unsigned exp [5]);
      for (int unsigned i = 0; i < 5; i++)
         check_eq($sformatf("%s_led%0d", tag, i), on_cnt[i], exp[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      Rst = 1'b1; Left = 1'b1; Right = 1'b1; Sw = 1'b0; Mode = 1'b0;
      step(3);
      check_eq("reset_led", 32'(Led), 0);
      check_eq("reset_pos", 32'(Pos), 0);
      check_eq("reset_dir", 32'(Dir), 0);
      Rst = 1'b0;
      step(200);
      check_eq("idle_pos", 32'(Pos), 0);
      check_eq("idle_dir", 32'(Dir), 0);

      // Wrap travel at the slow rate
      Left = 1'b0;
      step(6);
      check_eq("press_early_dir", 32'(Dir), 0);
      step(1);
      check_eq("press_latency_dir", 32'(Dir), 2);
      step(3);
      Left = 1'b1;
      wait_pos(25, n);
      check_eq("wrap_first_pos", 32'(Pos), 1);
      for (int k = 0; k < 5; k++) begin
         wait_pos(25, n);
         check_eq("wrap_period", n, 20);
         check_eq("wrap_pos", 32'(Pos), wrap_seq[k]);
      end

      // Bounce travel at the fast rate, starting from a fresh reset
      Rst = 1'b1;
      step(1);
      Rst = 1'b0; Sw = 1'b1; Mode = 1'b1; Left = 1'b0;
      step(10);
      Left = 1'b1;
      wait_pos(25, n);
      check_eq("bounce_first_pos", 32'(Pos), 1);
      check_eq("bounce_first_dir", 32'(Dir), 2);
      for (int k = 0; k < 8; k++) begin
         wait_pos(15, n);
         check_eq("bounce_period", n, 10);
         check_eq("bounce_pos", 32'(Pos), bnc_pos[k]);
         check_eq("bounce_dir", 32'(Dir), bnc_dir[k]);
      end

      // Speed change mid-count: sampled one edge later, then a full slow period
      step(4);
      Sw = 1'b0;
      wait_pos(30, n);
      check_eq("sw_change_delay", n, 21);
      check_eq("sw_change_pos", 32'(Pos), 2);

      // PWM brightness
      Mode = 1'b0;
      measure();
      check_frame("pwm_p2", frame_p2);
      for (int k = 0; k < 3; k++) wait_pos(25, n);
      check_eq("pwm_p0_pos", 32'(Pos), 0);
      measure();
      check_frame("pwm_p0_wrap", frame_p0w);
      Mode = 1'b1;
      measure();
      check_frame("pwm_p0_bounce", frame_p0b);

      // Debounce behaviour
      Mode = 1'b0;
      Right = 1'b0;
      step(3);
      Right = 1'b1;
      step(10);
      check_eq("deb_short_dir", 32'(Dir), 2);
      Right = 1'b0;
      step(8);
      check_eq("deb_accept_dir", 32'(Dir), 1);
      Right = 1'b1;
      step(10);
      Left = 1'b0; Right = 1'b0;
      step(10);
      check_eq("both_press_dir", 32'(Dir), 1);
      Left = 1'b1; Right = 1'b1;
      step(10);
      check_eq("both_release_dir", 32'(Dir), 1);

      // Reset in the middle of travel
      Left = 1'b0;
      step(8);
      Left = 1'b1;
      check_eq("rerun_dir", 32'(Dir), 2);
      for (int k = 0; k < 8 && Pos != 3'd3; k++) wait_pos(25, n);
      check_eq("pre_rst_pos", 32'(Pos), 3);
      check_eq("pre_rst_dir", 32'(Dir), 2);
      Rst = 1'b1;
      step(1);
      Rst = 1'b0;
      check_eq("midrst_pos", 32'(Pos), 0);
      check_eq("midrst_dir", 32'(Dir), 0);
      check_eq("midrst_led", 32'(Led), 0);
      step(60);
      check_eq("post_rst_pos", 32'(Pos), 0);
      check_eq("post_rst_dir", 32'(Dir), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
